// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types, constants and RATE decode for the 802.11a receive frame controller
package rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SIGNAL  = 3'd1,
        ST_SERVICE = 3'd2,
        ST_DATA    = 3'd3,
        ST_PAD     = 3'd4
    } state_t;

    localparam int SIG_W        = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    // Data bits per OFDM symbol; 0 marks an unsupported RATE code.
    function automatic logic [7:0] ndbps(input logic [3:0] rate);
        case (rate)
            RATE_6M:  return 8'd24;
            RATE_9M:  return 8'd36;
            RATE_12M: return 8'd48;
            RATE_18M: return 8'd72;
            RATE_24M: return 8'd96;
            RATE_36M: return 8'd144;
            RATE_48M: return 8'd192;
            RATE_54M: return 8'd216;
            default:  return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/rx_signal_checker.sv
// rtl/rx_signal_checker.sv - combinational SIGNAL field decode and validation (parity check under RXC_PARITY_CHECK_EN)
module rx_signal_checker
    import rx_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 4095
) (
    input  logic [23:0] sig,
    output logic [3:0]  rate,
    output logic [11:0] length,
    output logic [7:0]  ndbps_o,
    output logic        valid
);

`ifdef RXC_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    // Field extraction: LENGTH arrives LSB first, so it is bit-reversed out of sig.
    always_comb begin
        rate   = sig[23:20];
        length = '0;
        for (int i = 0; i < 12; i++) begin
            length[i] = sig[18-i];
        end
        ndbps_o = ndbps(rate);
        valid   = (ndbps_o != 8'd0)
                && !sig[19]
                && (length != 12'd0)
                && (int'(length) <= MAX_LEN)
                && (sig[5:0] == 6'd0)
                && (!(^sig[23:6]) || !PAR_CHECK);
    end

endmodule

// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - 802.11a RX frame controller: header hunt, SIGNAL check, SERVICE seeding, PSDU forward, PAD discard; option RXC_PARITY_CHECK_EN
module rx_frame_controller
    import rx_ctrl_pkg::*;
#(
    parameter int                HDR_W   = 12,
    parameter logic [HDR_W-1:0]  HEADER  = 12'hFFF,
    parameter int                MAX_LEN = 4095,
    parameter int                SEED_W  = 7,
    parameter int                CNT_W   = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEn,
    input  logic        iData,
    input  logic        iDSCMB_Out,
    output logic        oDSCMB_In,
    output logic        oDSCMB_SEN,
    output logic        oData,
    output logic        oValid,
    output logic [3:0]  oRate,
    output logic [11:0] oLength,
    output logic [7:0]  oNDBPS,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr
);

    // Only the previous HDR_W-1 / SIG_W-1 bits need storing; the newest bit is iData itself.
    state_t             state_q, state_d;
    logic [HDR_W-2:0]   hdr_q, hdr_d;
    logic [SIG_W-2:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         sym_cnt_q, sym_cnt_d;
    logic [2:0]         tail_cnt_q, tail_cnt_d;
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic [3:0]         rate_q, rate_d;
    logic [11:0]        length_q, length_d;
    logic [7:0]         ndbps_q, ndbps_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [HDR_W-1:0]   hdr_word;
    logic [SIG_W-1:0]   sig_word;
    logic [3:0]         chk_rate;
    logic [11:0]        chk_length;
    logic [7:0]         chk_ndbps;
    logic               chk_valid;
    logic [7:0]         sym_next;
    logic [CNT_W-1:0]   data_last;

    assign hdr_word  = {hdr_q, iData};
    assign sig_word  = {sig_q, iData};
    assign sym_next  = (sym_cnt_q == ndbps_q - 8'd1) ? 8'd0 : sym_cnt_q + 8'd1;
    assign data_last = CNT_W'({length_q, 3'b000}) - CNT_W'(1);

    rx_signal_checker #(.MAX_LEN(MAX_LEN)) u_checker (
        .sig     (sig_word),
        .rate    (chk_rate),
        .length  (chk_length),
        .ndbps_o (chk_ndbps),
        .valid   (chk_valid)
    );

    // State, shift registers, counters and registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            sig_q      <= '0;
            bit_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            tail_cnt_q <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            rate_q     <= '0;
            length_q   <= '0;
            ndbps_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            sig_q      <= sig_d;
            bit_cnt_q  <= bit_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            rate_q     <= rate_d;
            length_q   <= length_d;
            ndbps_q    <= ndbps_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; nothing moves unless the bit strobe is high.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        sig_d      = sig_q;
        bit_cnt_d  = bit_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        tail_cnt_d = tail_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        rate_d     = rate_q;
        length_d   = length_q;
        ndbps_d    = ndbps_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (iEn) begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_word == HEADER) begin
                        hdr_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = ST_SIGNAL;
                    end else begin
                        hdr_d = hdr_word[HDR_W-2:0];
                    end
                end
                ST_SIGNAL: begin
                    sig_d = sig_word[SIG_W-2:0];
                    if (bit_cnt_q == CNT_W'(SIG_W - 1)) begin
                        bit_cnt_d = '0;
                        if (chk_valid) begin
                            rate_d    = chk_rate;
                            length_d  = chk_length;
                            ndbps_d   = chk_ndbps;
                            sym_cnt_d = '0;
                            state_d   = ST_SERVICE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_SERVICE: begin
                    sym_cnt_d = sym_next;
                    if (bit_cnt_q == CNT_W'(SERVICE_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    sym_cnt_d = sym_next;
                    data_d    = iDSCMB_Out;
                    valid_d   = 1'b1;
                    if (bit_cnt_q == data_last) begin
                        bit_cnt_d  = '0;
                        tail_cnt_d = '0;
                        state_d    = ST_PAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_PAD: begin
                    sym_cnt_d = sym_next;
                    if (tail_cnt_q != 3'(TAIL_BITS)) begin
                        tail_cnt_d = tail_cnt_q + 3'd1;
                    end
                    // Current bit counts toward the tail; finish on the symbol boundary.
                    if ((tail_cnt_q >= 3'(TAIL_BITS - 1)) && (sym_next == 8'd0)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign oDSCMB_In  = iEn & iData;
    assign oDSCMB_SEN = iEn && (state_q == ST_SERVICE) && (bit_cnt_q < CNT_W'(SEED_W));
    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oRate      = rate_q;
    assign oLength    = length_q;
    assign oNDBPS     = ndbps_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oDone      = done_q;
    assign oErr       = err_q;

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb/tb_rx_frame_controller.sv - self-checking bench for rx_frame_controller
module tb_rx_frame_controller;

`ifdef RXC_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int SEED_W = 7;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iData;
    logic        iDSCMB_Out;
    logic        oDSCMB_In;
    logic        oDSCMB_SEN;
    logic        oData;
    logic        oValid;
    logic [3:0]  oRate;
    logic [11:0] oLength;
    logic [7:0]  oNDBPS;
    logic        oBusy;
    logic        oDone;
    logic        oErr;

    always #5 iClk = ~iClk;

    rx_frame_controller dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iData      (iData),
        .iDSCMB_Out (iDSCMB_Out),
        .oDSCMB_In  (oDSCMB_In),
        .oDSCMB_SEN (oDSCMB_SEN),
        .oData      (oData),
        .oValid     (oValid),
        .oRate      (oRate),
        .oLength    (oLength),
        .oNDBPS     (oNDBPS),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr)
    );

    typedef struct {
        logic [3:0] rate;
        int         len;
        bit         rsvd;
        logic [5:0] tail;
        bit         flip;
        bit         rnd;
        bit         exp_err;
        int         exp_ndbps;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    bit   exp_q[$];
    int   valid_cnt, done_cnt, err_cnt, sen_cnt;
    int   exp_rate, exp_len, exp_ndbps;
    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rate, input int len, input bit rsvd,
                                input logic [5:0] tail, input bit flip, input bit rnd,
                                input bit exp_err, input int exp_ndbps);
        vec_t v;
        v.rate = rate; v.len = len; v.rsvd = rsvd; v.tail = tail; v.flip = flip;
        v.rnd = rnd; v.exp_err = exp_err; v.exp_ndbps = exp_ndbps;
        return v;
    endfunction

    // Output monitor and scoreboard pop, sampled on the inactive edge.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oDSCMB_In !== (iEn & iData)) check("dscmb_in", int'(oDSCMB_In), int'(iEn & iData));
            if (oValid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("odata_unexpected_valid", 1, 0);
                end else begin
                    automatic bit e = exp_q.pop_front();
                    check("odata", int'(oData), int'(e));
                end
            end
            if (oDone) done_cnt++;
            if (oErr) err_cnt++;
            if (oDSCMB_SEN) sen_cnt++;
        end
    end

    task automatic idle(input int n);
        iEn = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic d, input bit rnd);
        if (rnd) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) break;
                iEn = 1'b0;
                iData = 1'($urandom_range(0, 1));
                iDSCMB_Out = 1'($urandom_range(0, 1));
                @(posedge iClk);
                #1;
            end
        end
        iEn = 1'b1;
        iData = b;
        iDSCMB_Out = d;
        @(posedge iClk);
        #1;
        iEn = 1'b0;
    endtask

    task automatic send_head_sig(input vec_t v);
        logic [23:0] s;
        s = '0;
        s[23:20] = v.rate;
        s[19] = v.rsvd;
        for (int i = 0; i < 12; i++) s[18-i] = v.len[i];
        s[6] = ^s[23:7];
        if (v.flip) s[6] = ~s[6];
        s[5:0] = v.tail;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), v.rnd);
        for (int i = 23; i >= 0; i--) send_bit(s[i], 1'($urandom_range(0, 1)), v.rnd);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int total;
        int pad;
        valid_cnt = 0; done_cnt = 0; err_cnt = 0; sen_cnt = 0;
        send_head_sig(v);
        if (v.exp_err) begin
            check($sformatf("v%0d_err_pulse", idx), int'(oErr), 1);
            check($sformatf("v%0d_busy_after_err", idx), int'(oBusy), 0);
        end else begin
            exp_rate = int'(v.rate);
            exp_len = v.len;
            exp_ndbps = v.exp_ndbps;
            check($sformatf("v%0d_busy", idx), int'(oBusy), 1);
            for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v.rnd);
            for (int i = 0; i < 8 * v.len; i++) begin
                automatic logic d = 1'($urandom_range(0, 1));
                exp_q.push_back(d);
                send_bit(1'($urandom_range(0, 1)), d, v.rnd);
            end
            total = 16 + 8 * v.len;
            pad = 6;
            while (((total + pad) % v.exp_ndbps) != 0) pad++;
            for (int i = 0; i < pad; i++) begin
                check($sformatf("v%0d_no_early_done", idx), done_cnt, 0);
                send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v.rnd);
            end
            check($sformatf("v%0d_done_pulse", idx), int'(oDone), 1);
        end
        idle(3);
        check($sformatf("v%0d_valid_cnt", idx), valid_cnt, v.exp_err ? 0 : 8 * v.len);
        check($sformatf("v%0d_done_cnt", idx), done_cnt, v.exp_err ? 0 : 1);
        check($sformatf("v%0d_err_cnt", idx), err_cnt, v.exp_err ? 1 : 0);
        check($sformatf("v%0d_sen_cnt", idx), sen_cnt, v.exp_err ? 0 : SEED_W);
        check($sformatf("v%0d_rate", idx), int'(oRate), exp_rate);
        check($sformatf("v%0d_length", idx), int'(oLength), exp_len);
        check($sformatf("v%0d_ndbps", idx), int'(oNDBPS), exp_ndbps);
        check($sformatf("v%0d_busy_end", idx), int'(oBusy), 0);
        check($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = mk(4'b1101,   1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,   24);
        vecs[1]  = mk(4'b0011, 100, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  216);
        vecs[2]  = mk(4'b0000,   5, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1,    0);
        vecs[3]  = mk(4'b1101,  10, 1'b0, 6'd0, 1'b1, 1'b0, PAR_ON,  24);
        vecs[4]  = mk(4'b0011, 100, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,  216);
        vecs[5]  = mk(4'b1111,   3, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,   36);
        vecs[6]  = mk(4'b0101,   0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1,    0);
        vecs[7]  = mk(4'b0111,   2, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,   72);
        vecs[8]  = mk(4'b1001,   1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1,    0);
        vecs[9]  = mk(4'b1011,   2, 1'b0, 6'd1, 1'b0, 1'b0, 1'b1,    0);
        vecs[10] = mk(4'b0001,   4, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  192);
        vecs[11] = mk(4'b1001,   1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,   96);
        vecs[12] = mk(4'b1011,   2, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  144);

        iRst = 1'b1; iEn = 1'b0; iData = 1'b0; iDSCMB_Out = 1'b0;
        exp_rate = 0; exp_len = 0; exp_ndbps = 0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_valid", int'(oValid), 0);
        check("rst_data", int'(oData), 0);
        check("rst_rate", int'(oRate), 0);
        check("rst_length", int'(oLength), 0);
        check("rst_ndbps", int'(oNDBPS), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done_err", int'({oDone, oErr}), 0);
        check("rst_sen", int'(oDSCMB_SEN), 0);
        iRst = 1'b0;
        idle(2);

        for (int i = 0; i < 13; i++) begin
            run_frame(i, vecs[i]);
            if (vecs[i].exp_err && !vecs[i].rnd && (i == 2)) begin
                check("err_width", int'(oErr), 0);
            end
        end

        // Reset in the middle of DATA, then a clean frame afterwards.
        valid_cnt = 0;
        send_head_sig(vecs[3].exp_err ? vecs[0] : vecs[3]);
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            automatic logic d = 1'($urandom_range(0, 1));
            exp_q.push_back(d);
            send_bit(1'b1, d, 1'b0);
        end
        check("mid_busy", int'(oBusy), 1);
        iRst = 1'b1;
        #1;
        check("mrst_valid", int'(oValid), 0);
        check("mrst_busy", int'(oBusy), 0);
        check("mrst_rate", int'(oRate), 0);
        check("mrst_length", int'(oLength), 0);
        check("mrst_ndbps", int'(oNDBPS), 0);
        check("mrst_done_err", int'({oDone, oErr}), 0);
        idle(2);
        iRst = 1'b0;
        exp_q.delete();
        exp_rate = 0; exp_len = 0; exp_ndbps = 0;
        idle(1);
        run_frame(13, vecs[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
